// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared types and helpers for the count block command sequencer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package count_ctrl_pkg;

    // Counter modo encodings, also used as the command mode field.
    localparam logic [1:0] PLUSONE    = 2'b00;
    localparam logic [1:0] MINUSONE   = 2'b01;
    localparam logic [1:0] MINUSTHREE = 2'b10;
    localparam logic [1:0] LOAD       = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] start;
        logic [3:0] len;
    } cmd_t;

    // True when the step about to execute on q carries the counter across
    // its 0/15 boundary.
    function automatic logic wrap_hit(input logic [1:0] mode, input logic [3:0] q);
        logic hit;
        hit = 1'b0;
        case (mode)
            PLUSONE:    hit = (q == 4'd15);
            MINUSONE:   hit = (q == 4'd0);
            MINUSTHREE: hit = (q <= 4'd2);
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/count_ctrl_fifo.sv
// count_ctrl_fifo: small command FIFO, DEPTH entries (power of 2, >= 2), sync active-low reset.
// Latency: a push is visible on pop_dat_o / empty_o one cycle later; pop data is read combinationally.
// Backpressure: push ignored while full_o; pop ignored while empty_o; push and pop may share a cycle.
// Ports: clk, rst_n_i | push_i/push_dat_i write side | pop_i/pop_dat_o read side | full_o, empty_o status.
module count_ctrl_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_dat_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_o   = (cnt_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the counters alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: sequences {mode,start,len} commands onto the 4-bit count block pins (load, len steps, done report).
// Latency: accept at edge N -> LOAD pins at N+1 -> done pulse at N+2+len when idle; all outputs registered.
// Backpressure: cmd_ready = !full with COUNT_CTRL_QUEUE_EN, else high only while idle with nothing held.
// Ports: clk, reset (sync, active-low) | cmd_valid/cmd_ready/cmd_mode/cmd_start/cmd_len command in |
//        abort | cnt_q counter Q in | cnt_enable/cnt_reset/cnt_modo/cnt_d counter pins |
//        busy, done, aborted, wraps status. Build option: COUNT_CTRL_QUEUE_EN (QDEPTH-entry queue).
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_start,
    input  logic [3:0] cmd_len,
    input  logic       abort,
    input  logic [3:0] cnt_q,
    output logic       cnt_enable,
    output logic       cnt_reset,
    output logic [1:0] cnt_modo,
    output logic [3:0] cnt_d,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [3:0] wraps
);

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("count_ctrl: QDEPTH must be a power of 2 and at least 2");
    end

    state_e     state_q, state_d;
    cmd_t       cur_q, cur_d;
    logic [3:0] steps_q, steps_d;
    logic [3:0] wraps_q, wraps_d;
    logic       aborted_q, aborted_d;
    logic       enable_q, enable_d;
    logic       creset_q;
    logic [1:0] modo_q, modo_d;
    logic [3:0] d_q, d_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;

    logic       pend;
    cmd_t       pend_cmd;
    logic       pop;
    logic       push;
    logic       wrap;
    cmd_t       in_cmd;

    assign in_cmd = {cmd_mode, cmd_start, cmd_len};
    assign push   = cmd_valid && cmd_ready;

`ifdef COUNT_CTRL_QUEUE_EN
    logic q_full;
    logic q_empty;

    count_ctrl_fifo #(
        .DW   ($bits(cmd_t)),
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n_i   (reset),
        .push_i    (push),
        .push_dat_i(in_cmd),
        .pop_i     (pop),
        .pop_dat_o (pend_cmd),
        .full_o    (q_full),
        .empty_o   (q_empty)
    );

    assign pend      = !q_empty;
    // ready_q only masks the reset window; afterwards fullness alone decides.
    assign ready_d   = 1'b1;
    assign cmd_ready = ready_q && !q_full;
`else
    cmd_t hold_q;
    logic hold_vld_q;
    logic hold_vld_d;

    assign hold_vld_d = push ? 1'b1 : (pop ? 1'b0 : hold_vld_q);
    assign pend       = hold_vld_q;
    assign pend_cmd   = hold_q;
    assign ready_d    = (state_d == ST_IDLE) && !hold_vld_d;
    assign cmd_ready  = ready_q;

    always_ff @(posedge clk) begin
        if (!reset) hold_vld_q <= 1'b0;
        else        hold_vld_q <= hold_vld_d;
    end

    always_ff @(posedge clk) begin
        if (push) hold_q <= in_cmd;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        steps_d   = steps_q;
        wraps_d   = wraps_q;
        aborted_d = aborted_q;
        pop       = 1'b0;
        wrap      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend) begin
                    pop       = 1'b1;
                    cur_d     = pend_cmd;
                    wraps_d   = 4'd0;
                    aborted_d = 1'b0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                steps_d = cur_q.len;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (cur_q.mode == LOAD || cur_q.len == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // cnt_q still holds the pre-step value; the step lands on the coming edge.
                wrap    = wrap_hit(cur_q.mode, cnt_q);
                steps_d = steps_q - 4'd1;
                if (wrap && wraps_q != 4'd15) wraps_d = wraps_q + 4'd1;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (steps_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pins are registered from the next state so they line up with it.
        enable_d = 1'b0;
        modo_d   = PLUSONE;
        d_d      = 4'd0;
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        case (state_d)
            ST_LOAD: begin
                enable_d = 1'b1;
                modo_d   = LOAD;
                d_d      = cur_d.start;
            end
            ST_RUN: begin
                enable_d = 1'b1;
                modo_d   = cur_d.mode;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            steps_q   <= 4'd0;
            wraps_q   <= 4'd0;
            aborted_q <= 1'b0;
            // Hold the counter in its own reset for as long as ours is asserted.
            enable_q  <= 1'b1;
            creset_q  <= 1'b1;
            modo_q    <= PLUSONE;
            d_q       <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            steps_q   <= steps_d;
            wraps_q   <= wraps_d;
            aborted_q <= aborted_d;
            enable_q  <= enable_d;
            creset_q  <= 1'b0;
            modo_q    <= modo_d;
            d_q       <= d_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign cnt_enable = enable_q;
    assign cnt_reset  = creset_q;
    assign cnt_modo   = modo_q;
    assign cnt_d      = d_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign wraps      = wraps_q;

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: drives count_ctrl with a behavioural count block on its pins and checks
// every command against an arithmetic model of the expected counter walk and completion report.
// Build option honoured: COUNT_CTRL_QUEUE_EN.
module tb_count_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_start;
    logic [3:0] cmd_len;
    logic       abort;
    logic [3:0] cnt_q;
    logic       cnt_enable;
    logic       cnt_reset;
    logic [1:0] cnt_modo;
    logic [3:0] cnt_d;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] wraps;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    count_ctrl #(.QDEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_start (cmd_start),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .cnt_q     (cnt_q),
        .cnt_enable(cnt_enable),
        .cnt_reset (cnt_reset),
        .cnt_modo  (cnt_modo),
        .cnt_d     (cnt_d),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .wraps     (wraps)
    );

    // The 4-bit count block the sequencer drives; starts away from 0 so reset is visible.
    logic [3:0] ctr_q = 4'd5;
    assign cnt_q = ctr_q;
    always @(posedge clk) begin
        if (cnt_enable) begin
            if (cnt_reset) ctr_q <= 4'd0;
            else begin
                case (cnt_modo)
                    2'b00:   ctr_q <= ctr_q + 4'd1;
                    2'b01:   ctr_q <= ctr_q - 4'd1;
                    2'b10:   ctr_q <= ctr_q - 4'd3;
                    default: ctr_q <= cnt_d;
                endcase
            end
        end
    end

    // Completion log used by the queued run.
    bit mon_en = 1'b0;
    int mon_wr[$];
    int mon_q[$];
    always @(negedge clk) begin
        if (mon_en && done === 1'b1) begin
            mon_wr.push_back(int'(wraps));
            mon_q.push_back(int'(cnt_q));
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int step_of(input logic [1:0] m);
        case (m)
            2'b00:   return 1;
            2'b01:   return -1;
            2'b10:   return -3;
            default: return 0;
        endcase
    endfunction

    // Counter value after k steps from s, in plain modular arithmetic.
    function automatic int q_after(input int s, input logic [1:0] m, input int k);
        return (s + step_of(m) * k + 256) % 16;
    endfunction

    // Wraps = number of 16-boundaries crossed by the unwrapped walk, saturated at 15.
    function automatic int wraps_after(input int s, input logic [1:0] m, input int k);
        int a, b, w;
        a = (s + 256) / 16;
        b = (s + 256 + step_of(m) * k) / 16;
        w = (a > b) ? a - b : b - a;
        return (w > 15) ? 15 : w;
    endfunction

    // ab = cycle index after acceptance on which abort is raised (1 = LOAD), 0 = none.
    task automatic run_cmd(input logic [1:0] m, input logic [3:0] s, input logic [3:0] l, input int ab);
        int  lfull, eff, last, guard;
        bit  exp_ab;
        lfull  = (m == 2'b11) ? 0 : int'(l);
        exp_ab = (ab >= 1) && (ab <= 1 + lfull);
        eff    = exp_ab ? ab - 1 : lfull;
        last   = 2 + eff;
        guard  = 0;
        while (cmd_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_wait", int'(cmd_ready), 1);
        if (cmd_ready !== 1'b1) return;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_start = s;
        cmd_len   = l;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_mode  = 2'($urandom);
        cmd_start = 4'($urandom);
        cmd_len   = 4'($urandom);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("load_enable", int'(cnt_enable), 1);
                chk("load_modo", int'(cnt_modo), 3);
                chk("load_d", int'(cnt_d), int'(s));
                chk("load_busy", int'(busy), 1);
                chk("load_done", int'(done), 0);
`ifndef COUNT_CTRL_QUEUE_EN
                chk("busy_ready", int'(cmd_ready), 0);
`endif
            end else if (c < last) begin
                chk("run_q", int'(cnt_q), q_after(int'(s), m, c - 2));
                chk("run_enable", int'(cnt_enable), 1);
                chk("run_modo", int'(cnt_modo), int'(m));
                chk("run_d", int'(cnt_d), 0);
                chk("run_done", int'(done), 0);
            end else begin
                chk("done_pulse", int'(done), 1);
                chk("done_wraps", int'(wraps), wraps_after(int'(s), m, eff));
                chk("done_aborted", int'(aborted), int'(exp_ab));
                chk("done_q", int'(cnt_q), q_after(int'(s), m, eff));
                chk("done_enable", int'(cnt_enable), 0);
            end
            abort = (c == ab);
        end
        @(negedge clk);
        abort = 1'b0;
        chk("done_one_cycle", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        int lfull, ab, guard, act;
        logic [1:0] m;
        logic [3:0] s, l;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 2'b00;
        cmd_start = 4'd0;
        cmd_len   = 4'd0;
        abort     = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_cnt_reset", int'(cnt_reset), 1);
        chk("rst_cnt_enable", int'(cnt_enable), 1);
        chk("rst_modo", int'(cnt_modo), 0);
        chk("rst_d", int'(cnt_d), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_wraps", int'(wraps), 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_counter_zero", int'(cnt_q), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_enable", int'(cnt_enable), 0);
        chk("post_rst_cnt_reset", int'(cnt_reset), 0);

        // Directed scenarios.
        run_cmd(2'b00, 4'd14, 4'd3, 0);
        run_cmd(2'b10, 4'd1, 4'd2, 0);
        run_cmd(2'b11, 4'd9, 4'd7, 0);
        run_cmd(2'b01, 4'd0, 4'd10, 4);
        run_cmd(2'b00, 4'd7, 4'd0, 0);
        run_cmd(2'b10, 4'd2, 4'd5, 1);
        run_cmd(2'b01, 4'd3, 4'd4, 5);
        run_cmd(2'b00, 4'd15, 4'd15, 6);

        // Randomized commands, with occasional aborts and idle-time abort pulses.
        for (int i = 0; i < 40; i++) begin
            m     = 2'($urandom_range(0, 3));
            s     = 4'($urandom_range(0, 15));
            l     = 4'($urandom_range(0, 15));
            lfull = (m == 2'b11) ? 0 : int'(l);
            ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 + lfull)) : 0;
            if ($urandom_range(0, 3) == 0) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
            run_cmd(m, s, l, ab);
        end

`ifdef COUNT_CTRL_QUEUE_EN
        begin
            int qm[6] = '{0, 0, 2, 3, 1, 2};
            int qs[6] = '{0, 14, 1, 9, 0, 5};
            int ql[6] = '{15, 3, 2, 7, 4, 6};
            mon_wr.delete();
            mon_q.delete();
            mon_en = 1'b1;
            for (int i = 0; i < 6; i++) begin
                cmd_valid = 1'b1;
                cmd_mode  = 2'(qm[i]);
                cmd_start = 4'(qs[i]);
                cmd_len   = 4'(ql[i]);
                guard = 0;
                while (cmd_ready !== 1'b1 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                @(posedge clk);
                @(negedge clk);
                if (i == 0) begin
                    // Let the long command start so the next four fill the queue.
                    cmd_valid = 1'b0;
                    guard = 0;
                    while (busy !== 1'b1 && guard < 10) begin
                        @(negedge clk);
                        guard++;
                    end
                end
                if (i == 4) chk("q_full_ready", int'(cmd_ready), 0);
            end
            cmd_valid = 1'b0;
            guard = 0;
            while (mon_wr.size() < 6 && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            repeat (4) @(negedge clk);
            chk("q_done_count", mon_wr.size(), 6);
            for (int i = 0; i < 6 && i < mon_wr.size(); i++) begin
                chk("q_order_wraps", mon_wr[i], wraps_after(qs[i], 2'(qm[i]), (qm[i] == 3) ? 0 : ql[i]));
                chk("q_order_q", mon_q[i], q_after(qs[i], 2'(qm[i]), (qm[i] == 3) ? 0 : ql[i]));
            end
            mon_en = 1'b0;
        end
`endif

        // Reset in the middle of a run.
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_rst_ready_wait", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_mode  = 2'b00;
        cmd_start = 4'd0;
        cmd_len   = 4'd15;
        @(posedge clk);
        @(negedge clk);
`ifdef COUNT_CTRL_QUEUE_EN
        cmd_start = 4'd3;
        cmd_len   = 4'd2;
        @(posedge clk);
        @(negedge clk);
`endif
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_running", int'(busy), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_cnt_reset", int'(cnt_reset), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_ready", int'(cmd_ready), 0);
        @(negedge clk);
        chk("mid_rst_counter_zero", int'(cnt_q), 0);
        chk("mid_rst_done2", int'(done), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rel_enable", int'(cnt_enable), 0);
        chk("mid_rel_cnt_reset", int'(cnt_reset), 0);
        act = 0;
        repeat (12) begin
            @(negedge clk);
            if (cnt_enable || done || busy) act++;
        end
        chk("flushed_stays_idle", act, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
